dmem_bytelane: RTL and testbench
================================

DMEM_BYTELANE -- requirements
Module: dmem_bytelane

Interface
REQ-001 Parameter ADDR_W, default 10, byte-address width; word depth = 2**(ADDR_W-2) SHALL be derived, with legal range 4..16.
REQ-002 Parameter LANES, default 4, byte lanes per word; data width = 8*LANES, and only 4 SHALL be supported in this generation.
REQ-003 Clk  in  1  single clock; every register SHALL update on its rising edge.
REQ-004 Reset_n  in  1  asynchronous, active-low reset.
REQ-005 Req  in  1  access request, sampled at the rising edge.
REQ-006 We  in  1  store when 1, load when 0.
REQ-007 Size  in  2  0=byte, 1=half, 2=word, 3=illegal.
REQ-008 Signed  in  1  load extension: 1=sign-extend, 0=zero-extend.
REQ-009 Ll / Sc  in  1 each  load-linked / store-conditional qualifiers; both are word-only.
REQ-010 Ad  in  ADDR_W  byte address, little-endian.
REQ-011 WrData  in  32  store data, right-aligned.
REQ-012 RdData  out  32  load result; holds its value when no load completes.
REQ-013 Rvalid  out  1  one-cycle pulse marking a valid RdData.
REQ-014 ScOk  out  1  one-cycle pulse on a successful Sc.
REQ-015 Misalign  out  1  one-cycle pulse on a rejected access.
REQ-016 Err  out  1  sticky error flag; cleared only by reset.

Function
REQ-017 Storage SHALL be LANES byte banks; lane i holds byte Ad[1:0]==i of each word.
REQ-018 An access SHALL be misaligned when any of these holds: Size=3; half with Ad[0]=1; word, Ll or Sc with Ad[1:0]!=0.
- Response: no write, no reservation change, Misalign=1 and Err=1 at the next edge, Rvalid=0.
REQ-019 Stores SHALL write only the addressed lanes:
- byte: lane Ad[1:0] <- WrData[7:0]
- half: lanes Ad[1]*2 and Ad[1]*2+1 <- WrData[15:0]
- word: all four lanes.
REQ-020 Loads SHALL have 1-cycle latency: a request accepted at edge N gives RdData and Rvalid=1 after edge N+1; the result is extracted from the addressed lanes and extended per Signed.
REQ-021 A load in the cycle after a store to the same word SHALL return the newly written bytes (read-after-write, no bypass bubble).
REQ-022 Priority when several qualifiers are set: Sc > Ll > We > load.
- Ll with We=1 SHALL be treated as Ll.
REQ-023 Ll SHALL load the word and set the reservation: ResValid=1, ResAddr=Ad[ADDR_W-1:2].
REQ-024 Sc success condition: ResValid=1 and ResAddr matches.
- On success: word written, ScOk=1, RdData=1, Rvalid=1.
- Otherwise: no write, ScOk=0, RdData=0, Rvalid=1.
REQ-025 Every Sc, successful or not, SHALL clear ResValid.
REQ-026 Any normal store that touches the reserved word SHALL clear ResValid, including a partial store to any of its bytes.
REQ-027 Req=0 SHALL leave memory and the reservation unchanged and give Rvalid=0, ScOk=0 and Misalign=0 at the next edge.
REQ-028 Address wrap-around does not exist: Ad always indexes inside the depth, and no out-of-range check is needed.

Reset
REQ-029 While Reset_n=0 the block SHALL hold RdData=0, Rvalid=0, ScOk=0, Misalign=0, Err=0 and ResValid=0, and the asynchronous assertion SHALL take effect immediately.
REQ-030 Memory contents SHALL NOT be initialised or altered by reset, and no file loading SHALL occur in RTL.
REQ-031 A request in the cycle where reset asserts SHALL be discarded, with no write and no pulse after release.
REQ-032 The first request SHALL be accepted at the first rising edge with Reset_n=1.

Structure
REQ-033 Package dmem_pkg SHALL hold:
- the Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD)
- the lane-count constant
- the extension helper function.
REQ-034 Sub-module dmem_lane SHALL be a single-port byte RAM (depth 2**(ADDR_W-2), write enable, registered read), instantiated LANES times.
REQ-035 The reservation, misalign detection and result extraction SHALL live in dmem_bytelane.

Verification
REQ-036 Word/byte store and load: store word 0x80FF7F01 at Ad=0x10.
- Byte load at 0x13, Signed=1 -> 0xFFFFFF80, Rvalid one cycle later.
- Byte load at 0x12, Signed=0 -> 0x000000FF.
REQ-037 Half load: same word as REQ-036, half load at 0x12, Signed=1 -> 0xFFFF80FF; half load at 0x10, Signed=0 -> 0x00007F01.
REQ-038 Misaligned accesses:
- Word store at 0x11 -> memory unchanged, Misalign pulse, Err stays 1.
- Size=3 load -> Misalign pulse, Rvalid=0.
REQ-039 LL/SC success then failure:
- Ll at 0x20, then Sc 0xDEADBEEF at 0x20 -> ScOk=1, RdData=1, and a word load returns 0xDEADBEEF.
- A second Sc at 0x20 -> RdData=0 and memory unchanged.
REQ-040 Reservation broken by a store: Ll at 0x20, byte store at 0x22, then Sc at 0x20 -> RdData=0, ScOk=0.
REQ-041 Mid-operation reset and read-after-write:
- Reset_n dropped with a load pending -> Rvalid=0 and Err=0 at once, and after release memory still holds its previous data.
- Back-to-back store/load to one word returns the new data.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the byte-lane data memory.
// Size encodings, lane count and load extension.
package dmem_pkg;

    localparam int LANE_CNT = 4;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_ILL  = 2'd3;

    // Pick the addressed bytes out of a word, then extend.
    function automatic logic [31:0] ext_load(
        input logic [31:0] w,
        input logic [1:0]  off,
        input logic [1:0]  sz,
        input logic        sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        unique case (1'b1)
            sz == SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            sz == SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default:       r = w;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dmem_bytelane_if.sv
// Request/response bundle of the byte-lane data memory.
// The master issues accesses, the slave answers them.
interface dmem_bytelane_if #(
    parameter int ADDR_W = 10
);
    logic              Req;
    logic              We;
    logic [1:0]        Size;
    logic              Signed;
    logic              Ll;
    logic              Sc;
    logic [ADDR_W-1:0] Ad;
    logic [31:0]       WrData;
    logic [31:0]       RdData;
    logic              Rvalid;
    logic              ScOk;
    logic              Misalign;
    logic              Err;

    modport master (
        output Req, We, Size, Signed, Ll, Sc, Ad, WrData,
        input  RdData, Rvalid, ScOk, Misalign, Err
    );

    modport slave (
        input  Req, We, Size, Signed, Ll, Sc, Ad, WrData,
        output RdData, Rvalid, ScOk, Misalign, Err
    );
endinterface

// File: rtl/dmem_lane.sv
// One byte bank: single-port RAM with registered read.
// Contents are never reset.
module dmem_lane #(
    parameter int AW = 8
) (
    input  logic          Clk,
    input  logic          We,
    input  logic [AW-1:0] Addr,
    input  logic [7:0]    WrData,
    output logic [7:0]    RdData
);
    logic [7:0] mem [2**AW];

    // write the byte when enabled, always register the read
    always_ff @(posedge Clk) begin
        if (We) begin
            mem[Addr] <= WrData;
        end
        RdData <= mem[Addr];
    end
endmodule

// File: rtl/dmem_bytelane.sv
// Byte-lane data memory with sub-word access and LL/SC.
// Load results appear one cycle after the bank read.
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int LANES  = LANE_CNT
) (
    input logic            Clk,
    input logic            Reset_n,
    dmem_bytelane_if.slave bus
);
    localparam int AW = ADDR_W - 2;

    logic [AW-1:0]    widx;
    logic [1:0]       off;
    logic [1:0]       esz;
    logic             is_sc;
    logic             is_ll;
    logic             is_st;
    logic             is_ld;
    logic             mis;
    logic             sc_hit;
    logic [LANES-1:0] lane_we;
    logic [7:0]       lane_wd [LANES];
    logic [7:0]       lane_q  [LANES];
    logic [31:0]      word_q;
    logic             res_valid;
    logic [AW-1:0]    res_addr;
    logic             p_ld;
    logic             p_sc;
    logic             p_ok;
    logic             p_sgn;
    logic [1:0]       p_sz;
    logic [1:0]       p_off;

    assign widx = bus.Ad[ADDR_W-1:2];
    assign off  = bus.Ad[1:0];

    // resolve qualifier priority and detect illegal alignment
    always_comb begin
        is_sc  = bus.Req & bus.Sc;
        is_ll  = bus.Req & ~bus.Sc & bus.Ll;
        is_st  = bus.Req & ~bus.Sc & ~bus.Ll & bus.We;
        is_ld  = bus.Req & ~bus.Sc & ~bus.Ll & ~bus.We;
        esz    = (bus.Ll | bus.Sc) ? SZ_WORD : bus.Size;
        mis    = bus.Req & ((bus.Size == SZ_ILL)
               | ((esz == SZ_HALF) & off[0])
               | ((esz == SZ_WORD) & (off != 2'd0)));
        sc_hit = is_sc & ~mis & res_valid
               & (res_addr == widx);
    end

    // per-lane write enables and replicated store data
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            lane_we[i] = 1'b0;
            lane_wd[i] = bus.WrData[8*i +: 8];
            unique case (1'b1)
                esz == SZ_BYTE: begin
                    lane_we[i] = (off == 2'(i));
                    lane_wd[i] = bus.WrData[7:0];
                end
                esz == SZ_HALF: begin
                    lane_we[i] = (off[1] == (i >= 2));
                    lane_wd[i] = bus.WrData[8*(i%2) +: 8];
                end
                default: lane_we[i] = 1'b1;
            endcase
            lane_we[i] = Reset_n
                & ((is_st & ~mis & lane_we[i]) | sc_hit);
        end
    end

    // reassemble the little-endian word from the banks
    always_comb begin
        word_q = '0;
        for (int i = 0; i < LANES; i++) begin
            word_q[8*i +: 8] = lane_q[i];
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        dmem_lane #(.AW(AW)) u_lane (
            .Clk    (Clk),
            .We     (lane_we[g]),
            .Addr   (widx),
            .WrData (lane_wd[g]),
            .RdData (lane_q[g])
        );
    end

    // accept stage: reservation, error flags, tag for the read
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            p_ld         <= 1'b0;
            p_sc         <= 1'b0;
            p_ok         <= 1'b0;
            p_sgn        <= 1'b0;
            p_sz         <= SZ_WORD;
            p_off        <= 2'd0;
            bus.Misalign <= 1'b0;
            bus.Err      <= 1'b0;
            res_valid    <= 1'b0;
            res_addr     <= '0;
        end else begin
            p_ld         <= (is_ld | is_ll) & ~mis;
            p_sc         <= is_sc & ~mis;
            p_ok         <= sc_hit;
            p_sgn        <= bus.Signed & is_ld;
            p_sz         <= esz;
            p_off        <= off;
            bus.Misalign <= mis;
            bus.Err      <= bus.Err | mis;
            if (is_sc & ~mis) begin
                res_valid <= 1'b0;
            end else if (is_ll & ~mis) begin
                res_valid <= 1'b1;
                res_addr  <= widx;
            end else if (is_st & ~mis & (widx == res_addr)) begin
                res_valid <= 1'b0;
            end
        end
    end

    // result stage: extend loads, report SC outcome
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.RdData <= '0;
            bus.Rvalid <= 1'b0;
            bus.ScOk   <= 1'b0;
        end else begin
            bus.Rvalid <= p_ld | p_sc;
            bus.ScOk   <= p_sc & p_ok;
            if (p_ld) begin
                bus.RdData <= ext_load(word_q, p_off, p_sz, p_sgn);
            end else if (p_sc) begin
                bus.RdData <= {31'd0, p_ok};
            end
        end
    end
endmodule

// File: tb/tb_dmem_bytelane.sv
// Directed bench for dmem_bytelane.
// Hand-computed expectations, checked with immediate assertions.
module tb_dmem_bytelane;
    import dmem_pkg::*;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    dmem_bytelane_if #(.ADDR_W(10)) bus ();

    dmem_bytelane #(.ADDR_W(10), .LANES(4)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic go(input logic        we,
                      input logic        ll,
                      input logic        sc,
                      input logic        sgn,
                      input logic [1:0]  sz,
                      input logic [9:0]  ad,
                      input logic [31:0] wd);
        bus.Req    = 1'b1;
        bus.We     = we;
        bus.Ll     = ll;
        bus.Sc     = sc;
        bus.Signed = sgn;
        bus.Size   = sz;
        bus.Ad     = ad;
        bus.WrData = wd;
        tick();
        bus.Req    = 1'b0;
    endtask

    initial begin
        bus.Req    = 1'b0;
        bus.We     = 1'b0;
        bus.Ll     = 1'b0;
        bus.Sc     = 1'b0;
        bus.Signed = 1'b0;
        bus.Size   = SZ_WORD;
        bus.Ad     = '0;
        bus.WrData = '0;

        tick();
        tick();
        chk("rst_rd", bus.RdData, 32'h0);
        chk("rst_rv", 32'(bus.Rvalid), 32'h0);
        chk("rst_sc", 32'(bus.ScOk), 32'h0);
        chk("rst_mis", 32'(bus.Misalign), 32'h0);
        chk("rst_err", 32'(bus.Err), 32'h0);
        Reset_n = 1'b1;

        go(1, 0, 0, 0, SZ_WORD, 10'h010, 32'h80FF7F01);
        chk("st_mis", 32'(bus.Misalign), 32'h0);
        chk("st_rv", 32'(bus.Rvalid), 32'h0);

        go(0, 0, 0, 1, SZ_BYTE, 10'h013, 32'h0);
        chk("lb_lat", 32'(bus.Rvalid), 32'h0);
        tick();
        chk("lb13_rv", 32'(bus.Rvalid), 32'h1);
        chk("lb13_rd", bus.RdData, 32'hFFFFFF80);
        tick();
        chk("rv_pulse", 32'(bus.Rvalid), 32'h0);
        chk("rd_hold", bus.RdData, 32'hFFFFFF80);

        go(0, 0, 0, 0, SZ_BYTE, 10'h012, 32'h0);
        tick();
        chk("lbu12", bus.RdData, 32'h000000FF);
        go(0, 0, 0, 1, SZ_HALF, 10'h012, 32'h0);
        tick();
        chk("lh12", bus.RdData, 32'hFFFF80FF);
        go(0, 0, 0, 0, SZ_HALF, 10'h010, 32'h0);
        tick();
        chk("lhu10", bus.RdData, 32'h00007F01);

        go(1, 0, 0, 0, SZ_WORD, 10'h011, 32'h12345678);
        chk("sw11_mis", 32'(bus.Misalign), 32'h1);
        chk("sw11_err", 32'(bus.Err), 32'h1);
        tick();
        chk("mis_pulse", 32'(bus.Misalign), 32'h0);
        chk("err_stick", 32'(bus.Err), 32'h1);
        go(0, 0, 0, 0, SZ_WORD, 10'h010, 32'h0);
        tick();
        chk("sw11_nowr", bus.RdData, 32'h80FF7F01);

        go(0, 0, 0, 0, SZ_ILL, 10'h010, 32'h0);
        chk("sz3_mis", 32'(bus.Misalign), 32'h1);
        tick();
        chk("sz3_rv", 32'(bus.Rvalid), 32'h0);

        go(1, 0, 0, 0, SZ_WORD, 10'h020, 32'h11111111);
        go(0, 1, 0, 0, SZ_WORD, 10'h020, 32'h0);
        tick();
        chk("ll_rd", bus.RdData, 32'h11111111);
        go(1, 0, 1, 0, SZ_WORD, 10'h020, 32'hDEADBEEF);
        tick();
        chk("sc1_ok", 32'(bus.ScOk), 32'h1);
        chk("sc1_rd", bus.RdData, 32'h1);
        chk("sc1_rv", 32'(bus.Rvalid), 32'h1);
        go(0, 0, 0, 0, SZ_WORD, 10'h020, 32'h0);
        tick();
        chk("sc1_mem", bus.RdData, 32'hDEADBEEF);
        go(1, 0, 1, 0, SZ_WORD, 10'h020, 32'hCAFEF00D);
        tick();
        chk("sc2_rd", bus.RdData, 32'h0);
        chk("sc2_ok", 32'(bus.ScOk), 32'h0);
        chk("sc2_rv", 32'(bus.Rvalid), 32'h1);
        go(0, 0, 0, 0, SZ_WORD, 10'h020, 32'h0);
        tick();
        chk("sc2_mem", bus.RdData, 32'hDEADBEEF);

        go(0, 1, 0, 0, SZ_WORD, 10'h020, 32'h0);
        tick();
        go(1, 0, 0, 0, SZ_BYTE, 10'h022, 32'h000000AA);
        go(1, 0, 1, 0, SZ_WORD, 10'h020, 32'h55555555);
        tick();
        chk("sc3_rd", bus.RdData, 32'h0);
        chk("sc3_ok", 32'(bus.ScOk), 32'h0);
        go(0, 0, 0, 0, SZ_WORD, 10'h020, 32'h0);
        tick();
        chk("sc3_mem", bus.RdData, 32'hDEAABEEF);

        go(1, 0, 0, 0, SZ_WORD, 10'h030, 32'hA5A5A5A5);
        go(0, 0, 0, 0, SZ_WORD, 10'h030, 32'h0);
        tick();
        chk("raw_word", bus.RdData, 32'hA5A5A5A5);
        go(1, 0, 0, 0, SZ_HALF, 10'h032, 32'h00001234);
        go(0, 0, 0, 0, SZ_WORD, 10'h030, 32'h0);
        tick();
        chk("raw_half", bus.RdData, 32'h1234A5A5);
        go(1, 1, 0, 0, SZ_WORD, 10'h030, 32'h0);
        tick();
        chk("llwe_rd", bus.RdData, 32'h1234A5A5);
        go(0, 0, 0, 0, SZ_WORD, 10'h030, 32'h0);
        tick();
        chk("llwe_mem", bus.RdData, 32'h1234A5A5);

        go(0, 0, 0, 0, SZ_WORD, 10'h010, 32'h0);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("arst_rv", 32'(bus.Rvalid), 32'h0);
        chk("arst_err", 32'(bus.Err), 32'h0);
        chk("arst_rd", bus.RdData, 32'h0);
        bus.Req    = 1'b1;
        bus.We     = 1'b1;
        bus.Size   = SZ_WORD;
        bus.Ad     = 10'h010;
        bus.WrData = 32'h0;
        tick();
        bus.Req = 1'b0;
        tick();
        Reset_n = 1'b1;
        tick();
        chk("rel_rv", 32'(bus.Rvalid), 32'h0);
        go(0, 0, 0, 0, SZ_WORD, 10'h010, 32'h0);
        tick();
        chk("rel_rv1", 32'(bus.Rvalid), 32'h1);
        chk("rel_mem", bus.RdData, 32'h80FF7F01);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
